// File: rtl/ring_pkg.sv
// Shared ring definitions: flit field positions, direction encodings and the
// saturating hop decrement applied when a flit leaves a router input port.
package ring_pkg;

  localparam int unsigned FLIT_W  = 64;
  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_HI  = 55;
  localparam int unsigned HOP_LO  = 48;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_state_e;

  // Hop count never wraps below zero.
  function automatic logic [7:0] hop_dec(input logic [7:0] hop);
    return (hop == 8'd0) ? 8'd0 : hop - 8'd1;
  endfunction

endpackage

// File: rtl/router_pe_in_port_if.sv
// Link and switch handshake bundle of the router PE input port.
//   pe_si/pe_ri/pe_di : NIC -> router link (send strobe, ready, flit)
//   req_cw/req_ccw    : requests to the cw/ccw output arbiters
//   out_gnt/out_data  : grant for the asserted request, flit offered to switch
// master = NIC/switch side, slave = input port.
interface router_pe_in_port_if
  import ring_pkg::*;
#(
  parameter int unsigned DW = FLIT_W
) ();

  logic          pe_si;
  logic          pe_ri;
  logic [DW-1:0] pe_di;
  logic          req_cw;
  logic          req_ccw;
  logic          out_gnt;
  logic [DW-1:0] out_data;

  modport master (
    output pe_si, pe_di, out_gnt,
    input  pe_ri, req_cw, req_ccw, out_data
  );

  modport slave (
    input  pe_si, pe_di, out_gnt,
    output pe_ri, req_cw, req_ccw, out_data
  );

endinterface

// File: rtl/vc_slot.sv
// One-entry flit buffer with an EMPTY/FULL state bit.
//   clk, reset : clock, asynchronous active-low reset
//   wr_en      : store wr_data and mark FULL
//   rd_en      : mark EMPTY (entry consumed)
//   full       : entry holds a valid flit
//   data       : stored flit
module vc_slot
  import ring_pkg::*;
#(
  parameter int unsigned DW = FLIT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic          full,
  output logic [DW-1:0] data
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SlotEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Write and read never target the same slot in one cycle (polarity
  // separates them); write takes precedence defensively.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SlotEmpty: begin
        if (wr_en) begin
          state_d = SlotFull;
          data_d  = wr_data;
        end
      end
      SlotFull: begin
        if (wr_en) begin
          data_d = wr_data;
        end else if (rd_en) begin
          state_d = SlotEmpty;
        end
      end
      default: state_d = SlotEmpty;
    endcase
  end

  assign full = (state_q == SlotFull);
  assign data = data_q;

endmodule

// File: rtl/router_pe_in_port.sv
// Router input port terminating the NIC link. One flit buffer per VC; the
// link fills VC `polarity` while the switch drains the other VC, so fill and
// drain never collide. Dispatched flits are routed by their dir bit and
// leave with the hop count decremented (saturating at zero).
//   clk, reset : clock, asynchronous active-low reset
//   polarity   : router-wide phase bit, toggles every cycle
//   bus        : link + switch handshake (slave side)
//   vc_err     : sticky, a flit arrived whose VC bit differed from polarity
//   flit_cnt   : wrapping count of accepted flits
module router_pe_in_port
  import ring_pkg::*;
#(
  parameter int unsigned DW = FLIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                polarity,
  router_pe_in_port_if.slave  bus,
  output logic                vc_err,
  output logic [15:0]         flit_cnt
);

  logic          pe_ri;
  logic          accept;
  logic [1:0]    wr_en;
  logic [1:0]    rd_en;
  logic [1:0]    full;
  logic [1:0]    elig;
  logic [DW-1:0] slot_data [2];
  logic [DW-1:0] sel_flit;
  logic [DW-1:0] out_flit;

  logic          vc_err_q, vc_err_d;
  logic [15:0]   flit_cnt_q, flit_cnt_d;

  vc_slot #(
    .DW (DW)
  ) u_slot0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en[0]),
    .wr_data (bus.pe_di),
    .rd_en   (rd_en[0]),
    .full    (full[0]),
    .data    (slot_data[0])
  );

  vc_slot #(
    .DW (DW)
  ) u_slot1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en[1]),
    .wr_data (bus.pe_di),
    .rd_en   (rd_en[1]),
    .full    (full[1]),
    .data    (slot_data[1])
  );

  always_comb begin
    pe_ri  = ~full[polarity];
    accept = bus.pe_si & pe_ri;
    wr_en  = {accept & polarity, accept & ~polarity};

    // A VC may only dispatch in the phase opposite its own number, so at
    // most one VC is eligible and no arbitration is needed.
    elig   = {full[1] & ~polarity, full[0] & polarity};

    sel_flit = '0;
    if (elig[0]) begin
      sel_flit = slot_data[0];
    end else if (elig[1]) begin
      sel_flit = slot_data[1];
    end

    out_flit                = sel_flit;
    out_flit[HOP_HI:HOP_LO] = hop_dec(sel_flit[HOP_HI:HOP_LO]);

    rd_en = elig & {2{bus.out_gnt}};
  end

  assign bus.pe_ri    = pe_ri;
  assign bus.req_cw   = (|elig) & (sel_flit[DIR_BIT] == DIR_CW);
  assign bus.req_ccw  = (|elig) & (sel_flit[DIR_BIT] == DIR_CCW);
  assign bus.out_data = out_flit;

  always_comb begin
    vc_err_d   = vc_err_q;
    flit_cnt_d = flit_cnt_q;
    if (accept) begin
      flit_cnt_d = flit_cnt_q + 16'd1;
      if (bus.pe_di[VC_BIT] != polarity) begin
        vc_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vc_err_q   <= 1'b0;
      flit_cnt_q <= '0;
    end else begin
      vc_err_q   <= vc_err_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign vc_err   = vc_err_q;
  assign flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_router_pe_in_port.sv
module tb_router_pe_in_port;
  import ring_pkg::*;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        polarity = 1'b0;
  logic        vc_err;
  logic [15:0] flit_cnt;

  router_pe_in_port_if bus_if ();

  router_pe_in_port #(
    .DW (64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .bus      (bus_if),
    .vc_err   (vc_err),
    .flit_cnt (flit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) polarity <= ~polarity;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        si;
    logic [63:0] di;
    logic        gnt;
    logic        ri;
    logic        cw;
    logic        ccw;
    logic [63:0] od;
    logic [15:0] cnt;
  } vec_t;

  vec_t        vt [9];
  logic [63:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ri, input logic cw, input logic ccw,
                            input logic [63:0] od);
    check({tag, "_pe_ri"}, 64'(bus_if.pe_ri), 64'(ri));
    check({tag, "_req_cw"}, 64'(bus_if.req_cw), 64'(cw));
    check({tag, "_req_ccw"}, 64'(bus_if.req_ccw), 64'(ccw));
    check({tag, "_out_data"}, bus_if.out_data, od);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic si, input logic [63:0] di, input logic gnt);
    bus_if.pe_si   = si;
    bus_if.pe_di   = di;
    bus_if.out_gnt = gnt;
  endtask

  // Called at a negedge; polarity toggles every cycle so one step suffices.
  task automatic align(input logic p);
    if (polarity !== p) step();
  endtask

  function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [7:0] hop,
                                     input logic [47:0] pl);
    return {vc, dir, 6'b0, hop, pl};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f;
    int          ndone;

    drive(1'b0, 64'h0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("in_reset", 1'b1, 1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_outs($sformatf("post_reset%0d", i), 1'b1, 1'b0, 1'b0, 64'h0);
      check($sformatf("post_reset%0d_cnt", i), 64'(flit_cnt), 64'd0);
      step();
    end

    // Table: each row = expected outputs of this cycle, then inputs for the
    // edge that ends it. Row 0 is a polarity-0 cycle; rows alternate.
    vt[0] = '{1'b1, 64'h0005_0000_0000_00AA, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 16'd0};
    vt[1] = '{1'b1, 64'hC000_0000_0000_0001, 1'b1, 1'b1, 1'b1, 1'b0,
              64'h0004_0000_0000_00AA, 16'd1};
    vt[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hC000_0000_0000_0001, 16'd2};
    vt[3] = '{1'b1, 64'h8002_0000_0000_0055, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'd2};
    vt[4] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8001_0000_0000_0055, 16'd3};
    vt[5] = '{1'b1, 64'h0000_0000_0000_0BAD, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 16'd3};
    vt[6] = '{1'b1, 64'h4007_0000_0000_0077, 1'b1, 1'b1, 1'b1, 1'b0,
              64'h8001_0000_0000_0055, 16'd3};
    vt[7] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h4006_0000_0000_0077, 16'd4};
    vt[8] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 16'd4};

    align(1'b0);
    for (int i = 0; i < 9; i++) begin
      check_outs($sformatf("vec%0d", i), vt[i].ri, vt[i].cw, vt[i].ccw, vt[i].od);
      check($sformatf("vec%0d_cnt", i), 64'(flit_cnt), 64'(vt[i].cnt));
      drive(vt[i].si, vt[i].di, vt[i].gnt);
      step();
    end
    drive(1'b0, 64'h0, 1'b0);

    // Withheld grant on VC0 while VC1 keeps flowing.
    align(1'b0);
    drive(1'b1, 64'h0009_0000_0000_00F0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      check_outs($sformatf("hold%0d_p1", k), 1'b1, 1'b1, 1'b0, 64'h0008_0000_0000_00F0);
      drive(1'b1, mk(1'b1, 1'b1, 8'(k + 3), 48'(k)), 1'b0);
      step();
      check_outs($sformatf("hold%0d_p0", k), 1'b0, 1'b0, 1'b1,
                 mk(1'b1, 1'b1, 8'(k + 2), 48'(k)));
      drive(1'b0, 64'h0, 1'b1);
      step();
    end
    check_outs("hold_release", 1'b1, 1'b1, 1'b0, 64'h0008_0000_0000_00F0);
    drive(1'b0, 64'h0, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0);
    check_outs("hold_done", 1'b1, 1'b0, 1'b0, 64'h0);
    check("hold_cnt", 64'(flit_cnt), 64'd11);
    check("hold_vc_err", 64'(vc_err), 64'd0);

    // Wrong VC bit at polarity 0: lands in VC0 and sets the sticky error.
    align(1'b0);
    drive(1'b1, 64'h8000_0000_0000_0011, 1'b0);
    step();
    check("vcerr_set", 64'(vc_err), 64'd1);
    check_outs("vcerr_disp", 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0011);
    drive(1'b0, 64'h0, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0);
    check("vcerr_vc0_free", 64'(bus_if.pe_ri), 64'd1);
    repeat (3) step();
    check("vcerr_sticky", 64'(vc_err), 64'd1);

    // Back-to-back from a fresh reset.
    reset = 1'b0;
    @(negedge clk);
    check("b2b_reset_vc_err", 64'(vc_err), 64'd0);
    check("b2b_reset_cnt", 64'(flit_cnt), 64'd0);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 22; c++) begin
      if (bus_if.req_cw || bus_if.req_ccw) begin
        if (exp_q.size() == 0) begin
          check($sformatf("b2b_spurious%0d", c), bus_if.out_data, 64'h0);
        end else begin
          f = exp_q.pop_front();
          check($sformatf("b2b_out%0d", ndone), bus_if.out_data, f);
          check($sformatf("b2b_dir%0d", ndone), 64'(bus_if.req_ccw), 64'(f[DIR_BIT]));
          ndone++;
        end
      end
      if (c < 20) begin
        check($sformatf("b2b_ready%0d", c), 64'(bus_if.pe_ri), 64'd1);
        f = mk(polarity, 1'(c), 8'(c + 1), 48'(32'hA000 + c));
        exp_q.push_back(mk(polarity, 1'(c), 8'(c), 48'(32'hA000 + c)));
        drive(1'b1, f, 1'b1);
      end else begin
        drive(1'b0, 64'h0, 1'b1);
      end
      step();
    end
    drive(1'b0, 64'h0, 1'b0);
    check("b2b_count", 64'(ndone), 64'd20);
    check("b2b_flit_cnt", 64'(flit_cnt), 64'd20);
    check("b2b_leftover", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with both VCs full.
    align(1'b0);
    drive(1'b1, 64'h0003_0000_0000_0123, 1'b0);
    step();
    drive(1'b1, 64'hC00A_0000_0000_0456, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0);
    check_outs("both_full", 1'b0, 1'b0, 1'b1, 64'hC009_0000_0000_0456);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", 1'b1, 1'b0, 1'b0, 64'h0);
    check("async_rst_cnt", 64'(flit_cnt), 64'd0);
    check("async_rst_vc_err", 64'(vc_err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_outs($sformatf("after_rst%0d", i), 1'b1, 1'b0, 1'b0, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_pe_in_port.md
# router_pe_in_port

Router input port that terminates the NIC's outgoing link (`net_so`/`net_ro`/`net_do`/`net_polarity`) on the router side of the ring. It holds one 64-bit flit per virtual channel (VC0/VC1) in two one-entry buffers. It routes each flit to the clockwise or counter-clockwise output by its direction bit and presents it to the router's output arbitration with the hop field decremented. Link-side acceptance and switch-side dispatch are phase-separated by the router-wide polarity signal.

## Interface
Parameters:
- `DW`, 64: flit width; bit positions below assume 64.

Flit fields:
- bit 63: VC.
- bit 62: dir, 0 = cw, 1 = ccw.
- bits 61:56: reserved, passed through.
- bits 55:48: hop count.
- bits 47:0: payload, passed through.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `polarity`  in  1  router-wide phase bit; toggles every cycle, generated elsewhere.
- `pe_si`  in  1  send-in strobe from NIC (driven by `net_so`).
- `pe_ri`  out  1  ready-in to NIC (drives `net_ro`).
- `pe_di`  in  DW  flit from NIC (driven by `net_do`).
- `req_cw`  out  1  request to cw output arbiter.
- `req_ccw`  out  1  request to ccw output arbiter.
- `out_gnt`  in  1  grant for the currently asserted request.
- `out_data`  out  DW  flit offered to the switch.
- `vc_err`  out  1  sticky error: a flit arrived whose bit 63 differs from `polarity`.
- `flit_cnt`  out  16  count of accepted flits, wraps.

## Operation
- Per-VC state is EMPTY or FULL, one bit `full[v]`; the flit is held in `buf[v]`.
- Link side:
  - `pe_ri = ~full[polarity]` (combinational).
  - Accept when `pe_si & pe_ri`: `buf[polarity] <= pe_di`, `full[polarity] <= 1`, `flit_cnt <= flit_cnt + 1`.
  - If `pe_si` is asserted while `pe_ri` = 0, the flit is ignored and nothing changes.
  - Accept with `pe_di[63] != polarity`: store the flit in VC `polarity` anyway and set `vc_err`. `vc_err` clears only on reset.
- Dispatch side:
  - VC `v` is eligible iff `full[v] & (polarity != v)`. At most one VC is eligible per cycle, so there is no VC arbitration.
  - If the eligible flit has dir = 0, assert `req_cw`; if dir = 1, assert `req_ccw`. Never both.
  - `out_data` is the eligible flit with hop' = (hop == 0) ? 0 : hop − 1, saturating; all other bits unchanged.
  - With no eligible VC: `req_cw` = `req_ccw` = 0 and `out_data` = 0.
  - `out_gnt` while a request is asserted: `full[v] <= 0` at the next edge. `out_gnt` with no request is ignored.
- Simultaneous events:
  - Accept and dispatch in the same cycle always target different VCs and both proceed.
  - The same VC can never be filled and drained in one cycle.
- Reset, asynchronous and asserted mid-operation:
  - `full` = 0, `buf` = 0, `vc_err` = 0, `flit_cnt` = 0.
  - Resulting outputs: `pe_ri` = 1, `req_*` = 0, `out_data` = 0. Any held flits are discarded.

## Timing
- Accept at edge k with polarity p. Cycle k+1 has polarity ~p, so the request appears combinationally in cycle k+1.
- With grant in cycle k+1, the VC frees at edge k+2, and `pe_ri` = 1 in cycle k+2 (polarity p again).
- Sustained throughput: one flit per VC per 2 cycles, which is one flit per cycle across both VCs.
- A withheld grant holds the request and data stable, and `pe_ri` stays 0 during every phase of that VC.
- `pe_ri`, `req_*` and `out_data` are combinational from registered state and `polarity`. There is no input-to-output path from `pe_si` or `pe_di`.

## Structure
- Shared package `ring_pkg` holds:
  - field constants: `VC_BIT`=63, `DIR_BIT`=62, `HOP_HI`=55, `HOP_LO`=48;
  - `DIR_CW`=0, `DIR_CCW`=1;
  - flit width 64.
- Sub-module `vc_slot` is instantiated twice. It has ports `wr_en`, `wr_data`, `rd_en`, `full`, `data`, and holds one entry with its EMPTY/FULL bit.
- The top level holds polarity gating, the route/hop logic, `vc_err` and `flit_cnt`.

## Test plan
- Reset release with polarity toggling: `pe_ri` = 1, `req_cw` = `req_ccw` = 0, `out_data` = 0, `flit_cnt` = 0.
- Inject 0x0005_0000_0000_00AA (VC0, cw, hop 5) at polarity 0:
  - next cycle, `req_cw` = 1 and `out_data` = 0x0004_0000_0000_00AA;
  - grant given, then VC0 is empty two cycles after accept.
- Inject 0xC000_0000_0000_0001 (VC1, ccw, hop 0) at polarity 1: `req_ccw` = 1 and `out_data` = 0xC000_0000_0000_0001, with the hop saturating at 0.
- Withhold `out_gnt` for 6 cycles on a full VC0:
  - `pe_ri` = 0 in every polarity-0 cycle;
  - VC1 traffic is still accepted and dispatched independently;
  - the request stays asserted with stable data.
- Inject a flit with bit 63 = 1 at polarity 0: it is stored in VC0, `vc_err` = 1 and stays set until reset.
- Back-to-back injection every cycle for 20 cycles with immediate grants: `flit_cnt` = 20, no flit is lost, and the output order matches the input order.
- Assert `reset` while both VCs are full: all outputs return to reset values immediately, asynchronously.
